// File: rtl/kernel_window_reader.sv
// Streaming 3x3 neighbourhood extractor for raster-order pixels.
// Two line memories feed three 3-tap shift registers; window and strobes are registered.
module kernel_window_reader #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 512,
   parameter int unsigned LINE_BITS = 10,
   parameter int unsigned ROWS      = 512,
   parameter int unsigned ROW_BITS  = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 data_in_valid,
   output logic [9*WIDTH-1:0]   window,
   output logic                 window_valid,
   output logic                 line_done,
   output logic                 frame_done,
   output logic                 busy
);

   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LINE_BITS-1:0] COL_LAST = LINE_BITS'(DEPTH - 1);
   localparam logic [ROW_BITS-1:0]  ROW_LAST = ROW_BITS'(ROWS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StPrime,
      StStream
   } state_t;

   state_t                 r_state;
   state_t                 w_state_d;
   logic [LINE_BITS-1:0]   r_col;
   logic [ROW_BITS-1:0]    r_row;

   logic [WIDTH-1:0]       r_lm1 [DEPTH];
   logic [WIDTH-1:0]       r_lm2 [DEPTH];

   // Each shift register holds {col-2, col-1, col} with the oldest pixel in the MSBs.
   logic [3*WIDTH-1:0]     r_top;
   logic [3*WIDTH-1:0]     r_mid;
   logic [3*WIDTH-1:0]     r_bot;

   logic [9*WIDTH-1:0]     r_window;
   logic                   r_window_valid;
   logic                   r_line_done;
   logic                   r_frame_done;

   logic                   w_accept;
   logic                   w_col_last;
   logic                   w_row_last;
   logic                   w_win_ok;
   logic [ADDR_W-1:0]      w_addr;
   logic [WIDTH-1:0]       w_lm1_rd;
   logic [WIDTH-1:0]       w_lm2_rd;
   logic [3*WIDTH-1:0]     w_top_next;
   logic [3*WIDTH-1:0]     w_mid_next;
   logic [3*WIDTH-1:0]     w_bot_next;

   assign w_accept   = data_in_valid;
   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);
   assign w_addr     = r_col[ADDR_W-1:0];
   assign w_lm1_rd   = r_lm1[w_addr];
   assign w_lm2_rd   = r_lm2[w_addr];

   assign w_top_next = {r_top[2*WIDTH-1:0], w_lm2_rd};
   assign w_mid_next = {r_mid[2*WIDTH-1:0], w_lm1_rd};
   assign w_bot_next = {r_bot[2*WIDTH-1:0], data_in};

   // Row/column gating suppresses both the priming lines and horizontal wrap-around.
   assign w_win_ok = w_accept && (r_state == StStream) &&
                     (r_row >= ROW_BITS'(2)) && (r_col >= LINE_BITS'(2));

   // Line memories are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lm1[w_addr] <= data_in;
         r_lm2[w_addr] <= w_lm1_rd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + ROW_BITS'(1);
         end else begin
            r_col <= r_col + LINE_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_d = StPrime;
            end
         end
         StPrime: begin
            if (w_accept && w_col_last && (r_row == ROW_BITS'(1))) begin
               w_state_d = StStream;
            end
         end
         StStream: begin
            if (w_accept && w_col_last && w_row_last) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_top <= '0;
         r_mid <= '0;
         r_bot <= '0;
      end else if (w_accept) begin
         r_top <= w_top_next;
         r_mid <= w_mid_next;
         r_bot <= w_bot_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_window       <= '0;
         r_window_valid <= 1'b0;
         r_line_done    <= 1'b0;
         r_frame_done   <= 1'b0;
      end else begin
         r_window_valid <= w_win_ok;
         r_line_done    <= w_accept && w_col_last;
         r_frame_done   <= w_accept && w_col_last && w_row_last;
         if (w_win_ok) begin
            r_window <= {w_top_next, w_mid_next, w_bot_next};
         end
      end
   end

   assign window       = r_window;
   assign window_valid = r_window_valid;
   assign line_done    = r_line_done;
   assign frame_done   = r_frame_done;
   assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_kernel_window_reader.sv
// Directed, table-driven bench for kernel_window_reader on a 4x4 frame (pixel = 4*row+col).
module tb_kernel_window_reader;

   localparam int unsigned W = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  data_in;
   logic          data_in_valid;
   logic [9*W-1:0] window;
   logic          window_valid;
   logic          line_done;
   logic          frame_done;
   logic          busy;

   always #5 clk = ~clk;

   kernel_window_reader #(
      .WIDTH     (W),
      .DEPTH     (4),
      .LINE_BITS (3),
      .ROWS      (4),
      .ROW_BITS  (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .window        (window),
      .window_valid  (window_valid),
      .line_done     (line_done),
      .frame_done    (frame_done),
      .busy          (busy)
   );

   typedef struct {
      logic [7:0] data;
      bit         exp_wv;
      int         widx;   // -1: window still holds its value from before this frame
      bit         exp_ld;
      bit         exp_fd;
      bit         exp_busy;
   } vec_t;

   vec_t          tbl [16];
   logic [71:0]   win_tab [4];
   localparam logic [71:0] OFF = {9{8'h40}};

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int idx, input logic [71:0] act,
                      input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic step(input bit v, input logic [7:0] d);
      data_in_valid = v;
      data_in       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int i, input bit wv, input int widx, input bit ld, input bit fd,
                          input bit bz);
      tbl[i].data     = 8'(i);
      tbl[i].exp_wv   = wv;
      tbl[i].widx     = widx;
      tbl[i].exp_ld   = ld;
      tbl[i].exp_fd   = fd;
      tbl[i].exp_busy = bz;
   endtask

   task automatic run_frame(input string tag, input bit gaps, input bit offs,
                            input logic [71:0] hold0);
      logic [71:0] add;
      logic [71:0] exp_w;
      add = offs ? OFF : '0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, tbl[i].data + (offs ? 8'h40 : 8'h00));
         exp_w = (tbl[i].widx < 0) ? hold0 : win_tab[tbl[i].widx] + add;
         chk({tag, ".wv"},   i, 72'(window_valid), 72'(tbl[i].exp_wv));
         chk({tag, ".win"},  i, window,            exp_w);
         chk({tag, ".ld"},   i, 72'(line_done),    72'(tbl[i].exp_ld));
         chk({tag, ".fd"},   i, 72'(frame_done),   72'(tbl[i].exp_fd));
         chk({tag, ".busy"}, i, 72'(busy),         72'(tbl[i].exp_busy));
         if (gaps) begin
            step(1'b0, 8'hA5);
            chk({tag, ".gap_wv"},   i, 72'(window_valid), 72'(0));
            chk({tag, ".gap_win"},  i, window,            exp_w);
            chk({tag, ".gap_ld"},   i, 72'(line_done),    72'(0));
            chk({tag, ".gap_fd"},   i, 72'(frame_done),   72'(0));
            chk({tag, ".gap_busy"}, i, 72'(busy),         72'(tbl[i].exp_busy));
         end
      end
   endtask

   initial begin
      win_tab[0] = 72'h00_01_02_04_05_06_08_09_0A;
      win_tab[1] = 72'h01_02_03_05_06_07_09_0A_0B;
      win_tab[2] = 72'h04_05_06_08_09_0A_0C_0D_0E;
      win_tab[3] = 72'h05_06_07_09_0A_0B_0D_0E_0F;

      //          i  wv widx ld fd busy
      set_vec( 0, 0, -1, 0, 0, 1);
      set_vec( 1, 0, -1, 0, 0, 1);
      set_vec( 2, 0, -1, 0, 0, 1);
      set_vec( 3, 0, -1, 1, 0, 1);
      set_vec( 4, 0, -1, 0, 0, 1);
      set_vec( 5, 0, -1, 0, 0, 1);
      set_vec( 6, 0, -1, 0, 0, 1);
      set_vec( 7, 0, -1, 1, 0, 1);
      set_vec( 8, 0, -1, 0, 0, 1);
      set_vec( 9, 0, -1, 0, 0, 1);
      set_vec(10, 1,  0, 0, 0, 1);
      set_vec(11, 1,  1, 1, 0, 1);
      set_vec(12, 0,  1, 0, 0, 1);
      set_vec(13, 0,  1, 0, 0, 1);
      set_vec(14, 1,  2, 0, 0, 1);
      set_vec(15, 1,  3, 1, 1, 0);

      reset         = 1'b0;
      data_in_valid = 1'b0;
      data_in       = '0;
      #12;
      chk("rst.win",  0, window,             '0);
      chk("rst.wv",   0, 72'(window_valid),  72'(0));
      chk("rst.ld",   0, 72'(line_done),     72'(0));
      chk("rst.fd",   0, 72'(frame_done),    72'(0));
      chk("rst.busy", 0, 72'(busy),          72'(0));
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 2; i++) begin
         step(1'b0, 8'h33);
         chk("idle.busy", i, 72'(busy),         72'(0));
         chk("idle.wv",   i, 72'(window_valid), 72'(0));
      end

      run_frame("f1",  1'b0, 1'b0, '0);
      run_frame("b2b", 1'b0, 1'b1, win_tab[3]);

      // Abort a frame part-way: outputs must clear asynchronously.
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 8'(i));
      end
      chk("pre_rst.busy", 0, 72'(busy), 72'(1));
      #2;
      reset = 1'b0;
      #1;
      chk("async.win",  0, window,            '0);
      chk("async.wv",   0, 72'(window_valid), 72'(0));
      chk("async.ld",   0, 72'(line_done),    72'(0));
      chk("async.fd",   0, 72'(frame_done),   72'(0));
      chk("async.busy", 0, 72'(busy),         72'(0));
      data_in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_frame("rst", 1'b0, 1'b0, '0);

      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_frame("gap", 1'b1, 1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kernel_window_reader.md
KERNEL_WINDOW_READER -- requirements
Module: kernel_window_reader

Interface
REQ-001 Parameter WIDTH, default 8, pixel bit width.
REQ-002 Parameter DEPTH, default 512, pixels per image line.
REQ-003 Parameter LINE_BITS, default 10, column counter width; SHALL hold DEPTH.
REQ-004 Parameter ROWS, default 512, lines per frame.
REQ-005 Parameter ROW_BITS, default 10, row counter width; SHALL hold ROWS.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  WIDTH  raster-order pixel.
REQ-009 data_in_valid  input  1  pixel accepted on any clk edge where high; no backpressure.
REQ-010 window  output  9*WIDTH  3x3 neighbourhood {p00,p01,p02,p10,p11,p12,p20,p21,p22}, p00 in MSBs.
REQ-011 window_valid  output  1  one-cycle strobe: window is valid.
REQ-012 line_done  output  1  one-cycle strobe: last pixel of a line accepted.
REQ-013 frame_done  output  1  one-cycle strobe: last pixel of a frame accepted.
REQ-014 busy  output  1  high while state is not IDLE.

Function
REQ-015 Two internal DEPTH x WIDTH line memories SHALL be kept: LM1 holds line row-1, LM2 holds line row-2, both indexed by the column counter col.
REQ-016 On an accepted pixel at (row,col): LM1[col] <= data_in, LM2[col] <= old LM1[col], same edge.
REQ-017 Three 3-deep shift registers SHALL shift on every accepted pixel: top takes old LM2[col], middle takes old LM1[col], bottom takes data_in.
REQ-018 p(i,j) SHALL equal pixel(row-2+i, col-2+j); p22 is the pixel just accepted.
REQ-019 window and window_valid SHALL be registered; latency exactly 1 cycle from acceptance edge.
REQ-020 window_valid SHALL be high only for an accepted pixel with row >= 2 and col >= 2; there SHALL be no horizontal wrap-around windows.
REQ-021 col SHALL increment per accepted pixel, wrapping DEPTH-1 -> 0; on wrap, row SHALL increment, wrapping ROWS-1 -> 0.
REQ-022 line_done SHALL pulse 1 cycle after acceptance of col == DEPTH-1.
REQ-023 frame_done SHALL pulse 1 cycle after acceptance of (ROWS-1, DEPTH-1), coincident with line_done and the final window_valid.
REQ-024 State machine: IDLE, PRIME, STREAM.
REQ-025 IDLE -> PRIME on first accepted pixel; PRIME -> STREAM on acceptance of (1, DEPTH-1); STREAM -> IDLE on acceptance of (ROWS-1, DEPTH-1).
REQ-026 window_valid SHALL never assert in IDLE or PRIME.
REQ-027 With data_in_valid low, all counters, memories, shift registers and state SHALL hold; all strobes SHALL be low.
REQ-028 Gaps in data_in_valid SHALL not change window contents or numbering; windows resume identically.
REQ-029 A new frame after frame_done SHALL start at (0,0) with no reset; stale memory content SHALL not produce window_valid before row 2.
REQ-030 window SHALL hold its last value when window_valid is low.

Reset
REQ-031 Reset low SHALL immediately force state IDLE, col = 0, row = 0, window = 0, window_valid = 0, line_done = 0, frame_done = 0, busy = 0.
REQ-032 Line memory contents SHALL not be cleared by reset.
REQ-033 Reset asserted mid-frame SHALL abort the frame; the next accepted pixel after release is (0,0).
REQ-034 Shift registers SHALL reset to 0.

Verification (DEPTH=4, ROWS=4, WIDTH=8, pixel value = 4*row+col)
REQ-035 Continuous 16 pixels -> window_valid exactly 4 times, first window = {00,01,02,04,05,06,08,09,0A}, 1 cycle after pixel 0x0A accepted.
REQ-036 Same frame, data_in_valid toggling 1/0 each cycle -> identical 4 windows, window_valid never on a cycle after a gap.
REQ-037 Frame end -> line_done 4 times; frame_done once, same cycle as window {05,06,07,09,0A,0B,0D,0E,0F}; busy falls same cycle.
REQ-038 Two back-to-back frames, second frame values +0x40 -> second frame yields 4 windows containing only +0x40 values; no window_valid during its rows 0-1.
REQ-039 Reset pulsed low after 7 pixels, then full frame -> outputs 0 immediately at assertion; subsequent windows match REQ-035.
REQ-040 col 0,1 of rows 2-3 -> window_valid low (no wrap-around window).
